// File: rtl/dma_mem_ctrl.sv
// dma_mem_ctrl: single-port word-addressed SRAM shared between a DMA port
// (strict priority, never stalls) and a Wishbone slave port that uses
// idle cycles. Reads return through a fixed-latency pipeline.
module dma_mem_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LAT    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_data_i,
  input  logic        dma_we,
  input  logic        dma_en,
  output logic [31:0] dma_data_o,
  output logic        dma_read_ack,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_data_i,
  input  logic [3:0]  wb_sel,
  input  logic        wb_we,
  input  logic        wb_en,
  output logic [31:0] wb_data_o,
  output logic        wb_ack
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_ACK  = 2'd2
  } wb_state_e;

  wb_state_e r_state;
  wb_state_e w_state_nxt;

  logic [31:0] r_mem [DEPTH];

  // Read pipeline; index 0 is stage 1, index LAT-1 is the exit stage.
  logic        r_vld [LAT];
  logic        r_src [LAT];
  logic [31:0] r_dat [LAT];

  logic [31:0] r_dma_hold;
  logic [31:0] r_wb_data;

  logic [ADDR_W-1:0] w_dma_idx;
  logic [ADDR_W-1:0] w_wb_idx;
  logic [ADDR_W-1:0] w_rd_idx;
  logic              w_dma_rd;
  logic              w_dma_wr;
  logic              w_wb_launch;
  logic              w_wb_rd;
  logic              w_wb_wr;
  logic              w_out_vld;
  logic              w_out_src;
  logic [31:0]       w_out_dat;
  logic              w_dma_ack;
  logic              w_wb_done;
  logic              w_unused;

  assign w_dma_idx   = dma_addr[ADDR_W+1:2];
  assign w_wb_idx    = wb_addr[ADDR_W+1:2];
  assign w_dma_rd    = dma_en & ~dma_we;
  assign w_dma_wr    = dma_en & dma_we;
  // WB only gets the array in cycles the DMA leaves idle.
  assign w_wb_launch = (r_state == WB_IDLE) & wb_en & ~dma_en;
  assign w_wb_rd     = w_wb_launch & ~wb_we;
  assign w_wb_wr     = w_wb_launch & wb_we;
  assign w_rd_idx    = dma_en ? w_dma_idx : w_wb_idx;

  assign w_out_vld   = r_vld[LAT-1];
  assign w_out_src   = r_src[LAT-1];
  assign w_out_dat   = r_dat[LAT-1];
  assign w_dma_ack   = w_out_vld & ~w_out_src;
  assign w_wb_done   = (r_state == WB_WAIT) & w_out_vld & w_out_src;

  assign w_unused = ^{dma_addr[31:ADDR_W+2], dma_addr[1:0],
                      wb_addr[31:ADDR_W+2], wb_addr[1:0]};

  // Array writes: DMA full-word writes, WB byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_dma_wr) begin
        r_mem[w_dma_idx] <= dma_data_i;
      end else if (w_wb_wr) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (wb_sel[b]) r_mem[w_wb_idx][8*b +: 8] <= wb_data_i[8*b +: 8];
        end
      end
    end
  end

  // Read pipeline: array read captured into stage 1, then shifted every cycle.
  always_ff @(posedge clk) begin
    r_src[0] <= ~dma_en;
    r_dat[0] <= r_mem[w_rd_idx];
    for (int unsigned i = 1; i < LAT; i++) begin
      r_src[i] <= r_src[i-1];
      r_dat[i] <= r_dat[i-1];
    end
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) r_vld[i] <= 1'b0;
    end else begin
      r_vld[0] <= w_dma_rd | w_wb_rd;
      for (int unsigned i = 1; i < LAT; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  // DMA read data is shown live on the ack cycle and held afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dma_hold <= '0;
    end else if (w_dma_ack) begin
      r_dma_hold <= w_out_dat;
    end
  end

  // WB next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WB_IDLE: if (w_wb_launch) w_state_nxt = wb_we ? WB_ACK : WB_WAIT;
      WB_WAIT: if (w_wb_done) w_state_nxt = WB_ACK;
      WB_ACK:  w_state_nxt = WB_IDLE;
      default: w_state_nxt = WB_IDLE;
    endcase
  end

  // WB state register and read-data latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= WB_IDLE;
      r_wb_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wb_done) r_wb_data <= w_out_dat;
    end
  end

  assign dma_read_ack = w_dma_ack;
  assign dma_data_o   = w_dma_ack ? w_out_dat : r_dma_hold;
  assign wb_ack       = (r_state == WB_ACK);
  assign wb_data_o    = r_wb_data;

endmodule

// File: tb/tb_dma_mem_ctrl.sv
// Bench for dma_mem_ctrl: directed sequences, a WB vector table and a
// randomized phase, all checked against a transaction-level reference model.
module tb_dma_mem_ctrl;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LAT    = 3;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dma_addr, dma_data_i, dma_data_o;
  logic        dma_we, dma_en, dma_read_ack;
  logic [31:0] wb_addr, wb_data_i, wb_data_o;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_en, wb_ack;

  always #5 clk = ~clk;

  dma_mem_ctrl #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .dma_addr(dma_addr), .dma_data_i(dma_data_i), .dma_we(dma_we), .dma_en(dma_en),
    .dma_data_o(dma_data_o), .dma_read_ack(dma_read_ack),
    .wb_addr(wb_addr), .wb_data_i(wb_data_i), .wb_sel(wb_sel), .wb_we(wb_we),
    .wb_en(wb_en), .wb_data_o(wb_data_o), .wb_ack(wb_ack)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: memory image, queue of DMA reads with due cycle,
  // and WB completion expressed as launch cycle plus fixed latency.
  typedef struct { int due; logic [31:0] d; } rd_t;
  logic [31:0] m [DEPTH];
  rd_t         dq[$];
  int          wb_free    = 0;
  int          wb_ack_cyc = -1;
  logic [31:0] wb_ack_dat;
  bit          wb_ack_rd;
  logic [31:0] last_dma = '0;
  logic [31:0] last_wb  = '0;

  // WB master request
  bit          wb_req = 0;
  bit          req_we;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_sel;

  // Observations
  int          seen_wb_cyc;
  logic [31:0] seen_wb_dat;
  int          dma_ack_cnt;
  int          ack_cyc_q[$];
  logic [31:0] ack_dat_q[$];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic eval_cycle();
    bit e_dack;
    bit e_wack;
    rd_t e;
    int  w;
    e_dack = (dq.size() > 0) && (dq[0].due == cyc);
    if (e_dack) begin
      last_dma = dq[0].d;
      void'(dq.pop_front());
    end
    e_wack = (cyc == wb_ack_cyc);
    if (e_wack && wb_ack_rd) last_wb = wb_ack_dat;

    chk("dma_read_ack", {31'b0, dma_read_ack}, {31'b0, e_dack});
    chk("dma_data_o", dma_data_o, last_dma);
    chk("wb_ack", {31'b0, wb_ack}, {31'b0, e_wack});
    chk("wb_data_o", wb_data_o, last_wb);

    if (dma_read_ack === 1'b1) begin
      dma_ack_cnt++;
      ack_cyc_q.push_back(cyc);
      ack_dat_q.push_back(dma_data_o);
    end
    if (wb_ack === 1'b1) begin
      seen_wb_cyc = cyc;
      seen_wb_dat = wb_data_o;
    end

    if (rst) begin
      dq.delete();
      wb_ack_cyc = -1;
      last_dma   = '0;
      last_wb    = '0;
      wb_free    = cyc + 1;
      wb_req     = 0;
    end else begin
      if (dma_en) begin
        w = widx(dma_addr);
        if (dma_we) begin
          m[w] = dma_data_i;
        end else begin
          e.due = cyc + int'(LAT);
          e.d   = m[w];
          dq.push_back(e);
        end
      end else if (wb_en && cyc >= wb_free) begin
        w = widx(wb_addr);
        if (wb_we) begin
          for (int b = 0; b < 4; b++) if (wb_sel[b]) m[w][8*b +: 8] = wb_data_i[8*b +: 8];
          wb_ack_rd  = 0;
          wb_ack_cyc = cyc + 1;
        end else begin
          wb_ack_dat = m[w];
          wb_ack_rd  = 1;
          wb_ack_cyc = cyc + 1 + int'(LAT);
        end
        wb_free = wb_ack_cyc + 1;
      end
      if (cyc == wb_ack_cyc) wb_req = 0;
    end
  endtask

  task automatic step();
    wb_en     = wb_req;
    wb_we     = req_we;
    wb_addr   = req_addr;
    wb_data_i = req_data;
    wb_sel    = req_sel;
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    req_we = we; req_addr = a; req_data = d; req_sel = s;
    wb_req = 1;
  endtask

  // One WB transaction with the DMA port idle; latency counted from the request cycle.
  task automatic wb_txn(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat, output logic [31:0] rd);
    int c0;
    seen_wb_cyc = -1;
    set_req(we, a, d, s);
    c0 = cyc;
    for (int n = 0; n < 60 && wb_req; n++) step();
    if (wb_req) begin
      total++; bad++;
      $display("FAIL wb_timeout cyc=%0d got=no_ack want=ack", cyc);
      wb_req = 0;
    end
    lat = (seen_wb_cyc < 0) ? -1 : seen_wb_cyc - c0;
    rd  = seen_wb_dat;
  endtask

  task automatic drain();
    dma_en = 0;
    for (int n = 0; n < 60 && (wb_req || dq.size() > 0); n++) step();
    step();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] w;
    w = $urandom_range(0, 63);
    return ($urandom & 32'hFFFF_F000) | (w << 2) | ($urandom & 32'h3);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    int          c0;

    tbl[0] = '{1'b1, 32'h0000_1100, 32'hFFFF_FFFF, 4'hF, 32'h0, 1};
    tbl[1] = '{1'b1, 32'h0000_1100, 32'h00AB_0000, 4'h4, 32'h0, 1};
    tbl[2] = '{1'b0, 32'h0000_1100, 32'h0,         4'h0, 32'hFFAB_FFFF, 4};
    tbl[3] = '{1'b0, 32'h0000_2000, 32'h0,         4'h0, 32'h0000_0001, 4};
    tbl[4] = '{1'b0, 32'h0000_10FC, 32'h0,         4'h0, 32'h0000_0040, 4};
    tbl[5] = '{1'b1, 32'h0000_3104, 32'h1122_3344, 4'hF, 32'h0, 1};
    tbl[6] = '{1'b1, 32'h0000_1107, 32'hAAAA_BBCC, 4'h3, 32'h0, 1};
    tbl[7] = '{1'b0, 32'h0000_0104, 32'h0,         4'h0, 32'h1122_BBCC, 4};
    tbl[8] = '{1'b1, 32'h0000_1104, 32'h0000_0000, 4'h0, 32'h0, 1};
    tbl[9] = '{1'b0, 32'hFFFF_F104, 32'h0,         4'h0, 32'h1122_BBCC, 4};

    rst = 1; dma_en = 0; dma_we = 0; dma_addr = '0; dma_data_i = '0;
    req_we = 0; req_addr = '0; req_data = '0; req_sel = '0;
    wb_en = 0; wb_we = 0; wb_addr = '0; wb_data_i = '0; wb_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 0;
    step();

    // Preload via WB
    for (int k = 0; k < 64; k++) begin
      wb_txn(1'b1, 32'h1000 + 4*k, k + 1, 4'hF, lat, rd);
      chk("preload_lat", lat, 1);
    end
    wb_txn(1'b0, 32'h1010, 32'h0, 4'h0, lat, rd);
    chk("wb_rd_lat", lat, LAT + 1);
    chk("wb_rd_data", rd, 32'd5);

    // DMA burst read
    ack_cyc_q.delete(); ack_dat_q.delete();
    c0 = cyc;
    for (int k = 0; k < 64; k++) begin
      dma_en = 1; dma_we = 0; dma_addr = 32'h1000 + 4*k;
      step();
    end
    drain();
    chk("burst_rd_count", ack_cyc_q.size(), 64);
    for (int k = 0; k < 64 && k < ack_cyc_q.size(); k++) begin
      chk("burst_rd_cyc", ack_cyc_q[k], c0 + int'(LAT) + k);
      chk("burst_rd_data", ack_dat_q[k], k + 1);
    end

    // Contention: WB read waits for the DMA burst to finish
    ack_cyc_q.delete(); ack_dat_q.delete();
    seen_wb_cyc = -1;
    set_req(1'b0, 32'h1000, 32'h0, 4'h0);
    c0 = cyc;
    for (int k = 0; k < 10; k++) begin
      dma_en = 1; dma_we = 0; dma_addr = 32'h1000 + 4*k;
      step();
    end
    drain();
    chk("cont_wb_ack_cyc", seen_wb_cyc, c0 + 10 + int'(LAT) + 1);
    chk("cont_wb_data", seen_wb_dat, 32'd1);
    chk("cont_dma_count", ack_cyc_q.size(), 10);
    for (int k = 0; k < 10 && k < ack_cyc_q.size(); k++) begin
      chk("cont_dma_cyc", ack_cyc_q[k], c0 + int'(LAT) + k);
      chk("cont_dma_data", ack_dat_q[k], k + 1);
    end

    // WB vector table: byte lanes, ignored address bits, wrap
    for (int i = 0; i < 10; i++) begin
      wb_txn(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].sel, lat, rd);
      chk("tbl_lat", lat, tbl[i].exp_lat);
      if (!tbl[i].we) chk("tbl_data", rd, tbl[i].exp_rd);
    end

    // Reset with two DMA reads in flight
    dma_ack_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      dma_en = 1; dma_we = 0; dma_addr = 32'h1100;
      step();
    end
    dma_en = 0; rst = 1;
    step();
    rst = 0;
    repeat (6) step();
    chk("rst_ack_count", dma_ack_cnt, 0);
    chk("rst_dma_data", dma_data_o, 32'h0);
    chk("rst_wb_data", wb_data_o, 32'h0);
    chk("rst_wb_ack", {31'b0, wb_ack}, 32'h0);
    wb_txn(1'b0, 32'h1100, 32'h0, 4'h0, lat, rd);
    chk("rst_mem_keep", rd, 32'hFFAB_FFFF);

    // DMA burst write (0x2000 aliases 0x1000 at this depth)
    dma_ack_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      dma_en = 1; dma_we = 1; dma_addr = 32'h2000 + 4*k; dma_data_i = 32'hA000 + k;
      step();
    end
    drain();
    chk("burst_wr_no_ack", dma_ack_cnt, 0);
    wb_txn(1'b0, 32'h20FC, 32'h0, 4'h0, lat, rd);
    chk("burst_wr_data", rd, 32'h0000_A03F);

    // Randomized traffic on the written region
    for (int n = 0; n < 600; n++) begin
      if (!wb_req && ($urandom % 3 == 0))
        set_req(1'(($urandom % 2)), rand_addr(), $urandom, 4'($urandom));
      dma_en     = ($urandom % 5) < 2;
      dma_we     = 1'($urandom % 2);
      dma_addr   = rand_addr();
      dma_data_i = $urandom;
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
